// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: writeback stage with its own MEM/WB register, load-miss hold, sub-word load extract, result select, x0/misalign write gating; WB_RETIRE_CNT_EN enables the retire counter
module wb_stage_pipe #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OFF_W      = $clog2(XLEN/8)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  validM,
    output logic                  readyM,
    input  logic [XLEN-1:0]       aluResultM,
    input  logic [XLEN-1:0]       pcPlus4M,
    input  logic [XLEN-1:0]       immExtM,
    input  logic [1:0]            resultSrcM,
    input  logic [2:0]            funct3M,
    input  logic                  regWriteM,
    input  logic [REG_ADDR_W-1:0] rdM,
    input  logic                  rdataValid,
    input  logic [XLEN-1:0]       rdata,
    output logic                  regWriteW,
    output logic [REG_ADDR_W-1:0] rdW,
    output logic [XLEN-1:0]       resultW,
    output logic                  misalignW,
    output logic [63:0]           retireCntW
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    logic [0:0]            state;
    logic [XLEN-1:0]       alu_q, pc4_q, imm_q;
    logic [1:0]            src_q;
    logic [2:0]            f3_q;
    logic                  we_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  is_load, retire, accept, mis;
    logic [OFF_W-1:0]      off;
    logic [XLEN-1:0]       sh, ld_val;

    assign is_load = src_q == 2'b01;
    assign retire  = (state == HOLD) && (!is_load || rdataValid);
    assign readyM  = (state == IDLE) || retire;
    assign accept  = validM && readyM;
    assign off     = alu_q[OFF_W-1:0];

    // single-entry MEM/WB register; a new capture overrides the retire of the old entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            alu_q <= '0;
            pc4_q <= '0;
            imm_q <= '0;
            src_q <= '0;
            f3_q  <= '0;
            we_q  <= 1'b0;
            rd_q  <= '0;
        end else begin
            state <= accept ? HOLD : (retire ? IDLE : state);
            if (accept) begin
                alu_q <= aluResultM;
                pc4_q <= pcPlus4M;
                imm_q <= immExtM;
                src_q <= resultSrcM;
                f3_q  <= funct3M;
                we_q  <= regWriteM;
                rd_q  <= rdM;
            end
        end
    end

    // align the cache word by the byte offset, then extend by load size and detect misalignment
    always_comb begin
        sh     = rdata >> {off, 3'b000};
        ld_val = sh;
        mis    = 1'b0;
        case (f3_q)
            3'b000: ld_val = XLEN'($signed(sh[7:0]));
            3'b100: ld_val = XLEN'(sh[7:0]);
            3'b001: begin
                ld_val = XLEN'($signed(sh[15:0]));
                mis    = off[0];
            end
            3'b101: begin
                ld_val = XLEN'(sh[15:0]);
                mis    = off[0];
            end
            3'b010: begin
                ld_val = XLEN'($signed(sh[31:0]));
                mis    = off[1:0] != 2'b00;
            end
            3'b110: begin
                ld_val = XLEN'(sh[31:0]);
                mis    = off[1:0] != 2'b00;
            end
            3'b011: mis = off != '0;
            default: ld_val = sh;
        endcase
    end

    assign resultW   = src_q == 2'b00 ? alu_q : src_q == 2'b01 ? ld_val : src_q == 2'b10 ? pc4_q : imm_q;
    assign rdW       = rd_q;
    assign misalignW = retire && is_load && mis;
    assign regWriteW = retire && we_q && (rd_q != '0) && !(is_load && mis);

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] cnt;

    // count every retire, including x0 and misaligned ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 64'd0;
        else if (retire) cnt <= cnt + 64'd1;
    end

    assign retireCntW = cnt;
`else
    assign retireCntW = 64'd0;
`endif
endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb_wb_stage_pipe: scoreboard bench for wb_stage_pipe with directed vectors
module tb_wb_stage_pipe;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        validM = 1'b0, readyM;
    logic [31:0] aluResultM = '0, pcPlus4M = '0, immExtM = '0, rdata = '0, resultW;
    logic [1:0]  resultSrcM = '0;
    logic [2:0]  funct3M = '0;
    logic        regWriteM = 1'b0, rdataValid = 1'b1, regWriteW, misalignW;
    logic [4:0]  rdM = '0, rdW;
    logic [63:0] retireCntW;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] res;
        logic        we;
        logic        mis;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   total = 0, bad = 0, nret = 0;

    wb_stage_pipe #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .validM(validM), .readyM(readyM),
        .aluResultM(aluResultM), .pcPlus4M(pcPlus4M), .immExtM(immExtM),
        .resultSrcM(resultSrcM), .funct3M(funct3M), .regWriteM(regWriteM), .rdM(rdM),
        .rdataValid(rdataValid), .rdata(rdata), .regWriteW(regWriteW), .rdW(rdW),
        .resultW(resultW), .misalignW(misalignW), .retireCntW(retireCntW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] rd, input logic [31:0] res, input logic we, input logic mis);
        mk.rd  = rd;
        mk.res = res;
        mk.we  = we;
        mk.mis = mis;
    endfunction

    task automatic set_in(input logic [1:0] src, input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm);
        validM     = 1'b1;
        resultSrcM = src;
        funct3M    = f3;
        rdM        = rd;
        aluResultM = alu;
        pcPlus4M   = pc;
        immExtM    = imm;
        regWriteM  = 1'b1;
    endtask

    // called at a falling edge; returns at the falling edge after the capturing rising edge
    task automatic issue(input logic [1:0] src, input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm);
        int   n = 0;
        logic r;
        set_in(src, f3, rd, alu, pc, imm);
        do begin
            #1 r = readyM;
            @(negedge clk);
            n++;
        end while (!r && n < 50);
        if (!r) chk("issue_timeout", r, 1);
        nret++;
    endtask

    // scoreboard monitor: any visible retire must match the oldest expectation
    always @(negedge clk) begin
        #2;
        if (rst_n && (regWriteW || misalignW)) begin
            if (q.size() == 0) chk("spurious_write", {regWriteW, misalignW}, 0);
            else begin
                me = q.pop_front();
                chk("mon_rd", rdW, me.rd);
                chk("mon_we", regWriteW, me.we);
                chk("mon_mis", misalignW, me.mis);
                if (!me.mis) chk("mon_result", resultW, me.res);
            end
        end
    end

    initial begin
        int w;
        logic [63:0] cexp;
        @(negedge clk);
        #1;
        chk("rst_ready", readyM, 1);
        chk("rst_we", regWriteW, 0);
        chk("rst_mis", misalignW, 0);
        chk("rst_rd", rdW, 0);
        chk("rst_result", resultW, 0);
        chk("rst_cnt", retireCntW, 0);
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(mk(5, 32'h0000_1234, 1, 0));
        issue(2'b00, 3'b000, 5, 32'h0000_1234, 0, 0);
        validM = 1'b0;
        #1 chk("alu_ready", readyM, 1);
        @(negedge clk);
        q.push_back(mk(6, 32'h0000_0104, 1, 0));
        issue(2'b10, 3'b000, 6, 32'h0, 32'h0000_0104, 0);
        q.push_back(mk(7, 32'hABCD_E000, 1, 0));
        issue(2'b11, 3'b000, 7, 32'h0, 0, 32'hABCD_E000);
        rdata = 32'h80FF_7F01;
        q.push_back(mk(1, 32'hFFFF_FF80, 1, 0));
        issue(2'b01, 3'b000, 1, 32'h0000_0103, 0, 0);
        q.push_back(mk(2, 32'h0000_0080, 1, 0));
        issue(2'b01, 3'b100, 2, 32'h0000_0203, 0, 0);
        q.push_back(mk(3, 32'hFFFF_80FF, 1, 0));
        issue(2'b01, 3'b001, 3, 32'h0000_0302, 0, 0);
        q.push_back(mk(4, 32'h0000_7F01, 1, 0));
        issue(2'b01, 3'b101, 4, 32'h0000_0400, 0, 0);
        issue(2'b00, 3'b000, 0, 32'hDEAD_BEEF, 0, 0);
        validM = 1'b0;
        #1 chk("x0_we", regWriteW, 0);
        @(negedge clk);
        q.push_back(mk(10, 32'h0, 0, 1));
        issue(2'b01, 3'b010, 10, 32'h0000_0002, 0, 0);
        q.push_back(mk(11, 32'h0, 0, 1));
        issue(2'b01, 3'b001, 11, 32'h0000_0001, 0, 0);
        validM = 1'b0;
        repeat (2) @(negedge clk);
`ifdef WB_RETIRE_CNT_EN
        cexp = 64'(nret);
`else
        cexp = 64'd0;
`endif
        chk("cnt_mid", retireCntW, cexp);
        rdataValid = 1'b0;
        rdata      = 32'h1234_5678;
        q.push_back(mk(12, 32'h1234_5678, 1, 0));
        issue(2'b01, 3'b010, 12, 32'h0000_0000, 0, 0);
        q.push_back(mk(13, 32'h0000_0055, 1, 0));
        set_in(2'b00, 3'b000, 13, 32'h0000_0055, 0, 0);
        repeat (3) begin
            #1;
            chk("miss_ready", readyM, 0);
            chk("miss_we", regWriteW, 0);
            @(negedge clk);
        end
        rdataValid = 1'b1;
        #1 chk("miss_release_ready", readyM, 1);
        @(negedge clk);
        validM = 1'b0;
        nret++;
        #1;
        chk("follow_we", regWriteW, 1);
        chk("follow_rd", rdW, 13);
        @(negedge clk);
        rdataValid = 1'b0;
        rdata      = 32'hCAFE_F00D;
        issue(2'b01, 3'b010, 9, 32'h0000_0000, 0, 0);
        validM = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("hold_rst_we", regWriteW, 0);
        chk("hold_rst_mis", misalignW, 0);
        chk("hold_rst_rd", rdW, 0);
        chk("hold_rst_result", resultW, 0);
        chk("hold_rst_cnt", retireCntW, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        rdataValid = 1'b1;
        #1;
        chk("post_rst_ready", readyM, 1);
        chk("post_rst_we", regWriteW, 0);
        repeat (2) @(negedge clk);
        q.push_back(mk(14, 32'h0000_0077, 1, 0));
        issue(2'b00, 3'b000, 14, 32'h0000_0077, 0, 0);
        validM = 1'b0;
        repeat (2) @(negedge clk);
`ifdef WB_RETIRE_CNT_EN
        cexp = 64'd1;
`else
        cexp = 64'd0;
`endif
        chk("cnt_post_rst", retireCntW, cexp);
        w = 0;
        while (q.size() > 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
